// File: rtl/operand_stack.sv
// operand_stack: typed 64-bit operand stack for the WebAssembly execute stage.
// Serves PUSH, POP1, POP2 and POP3 (the select operand path) with a one-cycle
// EXEC phase per accepted request, and raises sticky overflow/underflow traps.
// Optional feature macro: OPERAND_STACK_TYPE_CHECK_EN enables the POP3 operand
// type check (condition must be i32, both selected values must share a type).
module operand_stack #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [2:0]       op,
    input  logic [63:0]      push_data,
    input  logic [1:0]       push_type,
    output logic             ready,
    output logic             valid,
    output logic [63:0]      out0,
    output logic [63:0]      out1,
    output logic [63:0]      out2,
    output logic [1:0]       type0,
    output logic [1:0]       type1,
    output logic [1:0]       type2,
    output logic [PTR_W:0]   depth,
    output logic [3:0]       trap
);

    // Operation codes; 5..7 behave like NOP.
    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP1 = 3'd2;
    localparam logic [2:0] OP_POP2 = 3'd3;
    localparam logic [2:0] OP_POP3 = 3'd4;

    // Trap encodings shared with the CPU trap output.
    localparam logic [3:0] TRAP_NONE            = 4'd0;
    localparam logic [3:0] TRAP_STACK_OVERFLOW  = 4'd1;
    localparam logic [3:0] TRAP_STACK_UNDERFLOW = 4'd2;
`ifdef OPERAND_STACK_TYPE_CHECK_EN
    localparam logic [3:0] TRAP_TYPES_MISMATCH  = 4'd3;
    localparam logic [1:0] TYPE_I32             = 2'd0;
`endif

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        TRAPPED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [63:0]     data_q, data_d;
    logic [1:0]      dtype_q, dtype_d;
    logic [PTR_W:0]  depth_q, depth_d;
    logic [3:0]      trap_q, trap_d;
    logic            valid_q, valid_d;
    logic [63:0]     out0_q, out0_d, out1_q, out1_d, out2_q, out2_d;
    logic [1:0]      type0_q, type0_d, type1_q, type1_d, type2_q, type2_d;

    // Storage: values and tags, not reset (entries above depth are don't-care).
    logic [63:0]     mem_q  [DEPTH];
    logic [1:0]      tmem_q [DEPTH];
    logic            we;

    logic [PTR_W-1:0] wr_idx, idx0, idx1, idx2;
    logic [PTR_W:0]   pop_n;
    logic             op_valid;

    // Index arithmetic wraps in PTR_W bits; only used when enough entries exist.
    assign wr_idx = depth_q[PTR_W-1:0];
    assign idx0   = depth_q[PTR_W-1:0] - PTR_W'(1);
    assign idx1   = depth_q[PTR_W-1:0] - PTR_W'(2);
    assign idx2   = depth_q[PTR_W-1:0] - PTR_W'(3);

    assign op_valid = (op != OP_NOP) && (op <= OP_POP3);

    // Number of entries removed by the latched pop operation.
    always_comb begin
        pop_n = '0;
        case (op_q)
            OP_POP1: pop_n = (PTR_W+1)'(1);
            OP_POP2: pop_n = (PTR_W+1)'(2);
            OP_POP3: pop_n = (PTR_W+1)'(3);
            default: pop_n = '0;
        endcase
    end

    // Next-state, datapath and trap decisions for the three-state controller.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        dtype_d = dtype_q;
        depth_d = depth_q;
        trap_d  = trap_q;
        valid_d = 1'b0;
        out0_d  = out0_q;
        out1_d  = out1_q;
        out2_d  = out2_q;
        type0_d = type0_q;
        type1_d = type1_q;
        type2_d = type2_q;
        we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req && op_valid) begin
                    op_d    = op;
                    data_d  = push_data;
                    dtype_d = push_type;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (op_q == OP_PUSH) begin
                    if (depth_q == FULL) begin
                        trap_d  = TRAP_STACK_OVERFLOW;
                        state_d = TRAPPED;
                    end else begin
                        we      = 1'b1;
                        depth_d = depth_q + (PTR_W+1)'(1);
                        state_d = IDLE;
                    end
                end else if (depth_q < pop_n) begin
                    trap_d  = TRAP_STACK_UNDERFLOW;
                    state_d = TRAPPED;
                end else begin
                    valid_d = 1'b1;
                    depth_d = depth_q - pop_n;
                    state_d = IDLE;
                    out0_d  = mem_q[idx0];
                    type0_d = tmem_q[idx0];
                    out1_d  = '0;
                    type1_d = '0;
                    out2_d  = '0;
                    type2_d = '0;
                    if (op_q != OP_POP1) begin
                        out1_d  = mem_q[idx1];
                        type1_d = tmem_q[idx1];
                    end
                    if (op_q == OP_POP3) begin
                        out2_d  = mem_q[idx2];
                        type2_d = tmem_q[idx2];
                    end
`ifdef OPERAND_STACK_TYPE_CHECK_EN
                    if ((op_q == OP_POP3) &&
                        !((tmem_q[idx0] == TYPE_I32) && (tmem_q[idx1] == tmem_q[idx2]))) begin
                        trap_d  = TRAP_TYPES_MISMATCH;
                        state_d = TRAPPED;
                    end
`endif
                end
            end
            TRAPPED: begin
                state_d = TRAPPED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            dtype_q <= '0;
            depth_q <= '0;
            trap_q  <= TRAP_NONE;
            valid_q <= 1'b0;
            out0_q  <= '0;
            out1_q  <= '0;
            out2_q  <= '0;
            type0_q <= '0;
            type1_q <= '0;
            type2_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            dtype_q <= dtype_d;
            depth_q <= depth_d;
            trap_q  <= trap_d;
            valid_q <= valid_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            out2_q  <= out2_d;
            type0_q <= type0_d;
            type1_q <= type1_d;
            type2_q <= type2_d;
        end
    end

    // Stack array write; the write lands on the edge that ends EXEC.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_idx]  <= data_q;
            tmem_q[wr_idx] <= dtype_q;
        end
    end

    assign ready = (state_q == IDLE);
    assign valid = valid_q;
    assign out0  = out0_q;
    assign out1  = out1_q;
    assign out2  = out2_q;
    assign type0 = type0_q;
    assign type1 = type1_q;
    assign type2 = type2_q;
    assign depth = depth_q;
    assign trap  = trap_q;

endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack: push/pop, select operands, type mismatch,
// overflow, underflow with sticky trap, and asynchronous reset during EXEC.
module tb_operand_stack;

    localparam logic [2:0] PUSH = 3'd1;
    localparam logic [2:0] POP1 = 3'd2;
    localparam logic [2:0] POP2 = 3'd3;
    localparam logic [2:0] POP3 = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [63:0] push_data = '0;
    logic [1:0]  push_type = '0;
    logic        ready, valid;
    logic [63:0] out0, out1, out2;
    logic [1:0]  type0, type1, type2;
    logic [4:0]  depth;
    logic [3:0]  trap;

    int checks = 0;
    int errors = 0;

    operand_stack #(.DEPTH(16), .PTR_W(4)) dut (
        .clk(clk), .reset(reset), .req(req), .op(op),
        .push_data(push_data), .push_type(push_type),
        .ready(ready), .valid(valid),
        .out0(out0), .out1(out1), .out2(out2),
        .type0(type0), .type1(type1), .type2(type2),
        .depth(depth), .trap(trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Request handshake; returns 1 time unit after the edge that ends EXEC.
    task automatic do_op(input logic [2:0] o, input logic [63:0] d, input logic [1:0] t);
        int n;
        @(negedge clk);
        req = 1'b1; op = o; push_data = d; push_type = t;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 64'(ready), 64'd1);
        @(posedge clk);
        #1;
        req = 1'b0; op = 3'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_depth", 64'(depth), 64'd0);
        chk("rst_trap",  64'(trap),  64'd0);
        chk("rst_out0",  out0,       64'd0);
        chk("rst_type0", 64'(type0), 64'd0);
        reset = 1'b0;

        // Push then pop
        do_op(PUSH, 64'h11, 2'd1);
        chk("push_novalid", 64'(valid), 64'd0);
        chk("push_depth",   64'(depth), 64'd1);
        do_op(POP1, 64'h0, 2'd0);
        chk("pop1_valid", 64'(valid), 64'd1);
        chk("pop1_out0",  out0,       64'h11);
        chk("pop1_type0", 64'(type0), 64'd1);
        chk("pop1_out1",  out1,       64'd0);
        chk("pop1_out2",  out2,       64'd0);
        chk("pop1_depth", 64'(depth), 64'd0);
        chk("pop1_trap",  64'(trap),  64'd0);
        @(posedge clk); #1;
        chk("pop1_pulse_end", 64'(valid), 64'd0);
        chk("pop1_hold_out0", out0,       64'h11);

        // Select operands
        do_op(PUSH, 64'd5, 2'd0);
        do_op(PUSH, 64'd7, 2'd0);
        do_op(PUSH, 64'd1, 2'd0);
        chk("sel_depth3", 64'(depth), 64'd3);
        do_op(POP3, 64'h0, 2'd0);
        chk("sel_valid", 64'(valid), 64'd1);
        chk("sel_out0",  out0, 64'd1);
        chk("sel_out1",  out1, 64'd7);
        chk("sel_out2",  out2, 64'd5);
        chk("sel_types", 64'({type0, type1, type2}), 64'd0);
        chk("sel_depth", 64'(depth), 64'd0);
        chk("sel_trap",  64'(trap),  64'd0);

        // POP2 leaves out2 cleared
        do_op(PUSH, 64'hA, 2'd2);
        do_op(PUSH, 64'hB, 2'd3);
        do_op(POP2, 64'h0, 2'd0);
        chk("pop2_out0", out0, 64'hB);
        chk("pop2_out1", out1, 64'hA);
        chk("pop2_out2", out2, 64'd0);
        chk("pop2_types", 64'({type0, type1, type2}), 64'b11_10_00);

        // Type mismatch
        do_op(PUSH, 64'd5, 2'd1);
        do_op(PUSH, 64'd7, 2'd0);
        do_op(PUSH, 64'd1, 2'd0);
        do_op(POP3, 64'h0, 2'd0);
        chk("mm_valid", 64'(valid), 64'd1);
        chk("mm_out2",  out2, 64'd5);
        chk("mm_type2", 64'(type2), 64'd1);
        chk("mm_depth", 64'(depth), 64'd0);
        repeat (3) @(posedge clk);
        #1;
`ifdef OPERAND_STACK_TYPE_CHECK_EN
        chk("mm_trap",  64'(trap),  64'd3);
        chk("mm_ready", 64'(ready), 64'd0);
`else
        chk("mm_trap",  64'(trap),  64'd0);
        chk("mm_ready", 64'(ready), 64'd1);
`endif
        do_reset();

        // Overflow
        for (int i = 0; i < 16; i++) begin
            do_op(PUSH, 64'h100 + 64'(i), 2'(i % 4));
        end
        chk("ovf_full", 64'(depth), 64'd16);
        do_op(POP1, 64'h0, 2'd0);
        chk("ovf_top",      out0,       64'h10F);
        chk("ovf_top_type", 64'(type0), 64'd3);
        chk("ovf_depth15",  64'(depth), 64'd15);
        do_op(PUSH, 64'h10F, 2'd3);
        do_op(PUSH, 64'h999, 2'd0);
        chk("ovf_trap",  64'(trap),  64'd1);
        chk("ovf_depth", 64'(depth), 64'd16);
        chk("ovf_ready", 64'(ready), 64'd0);
        do_reset();
        chk("ovf_clear_trap", 64'(trap), 64'd0);

        // Underflow and sticky trap
        do_op(PUSH, 64'hAB, 2'd0);
        do_op(POP2, 64'h0, 2'd0);
        chk("udf_trap",  64'(trap),  64'd2);
        chk("udf_depth", 64'(depth), 64'd1);
        chk("udf_valid", 64'(valid), 64'd0);
        @(negedge clk);
        req = 1'b1; op = PUSH; push_data = 64'h77; push_type = 2'd0;
        repeat (4) @(negedge clk);
        req = 1'b0; op = 3'd0;
        chk("sticky_depth", 64'(depth), 64'd1);
        chk("sticky_trap",  64'(trap),  64'd2);
        chk("sticky_ready", 64'(ready), 64'd0);
        do_reset();

        // Reset mid-operation
        do_op(PUSH, 64'h33, 2'd0);
        chk("mid_pre_depth", 64'(depth), 64'd1);
        @(negedge clk);
        req = 1'b1; op = PUSH; push_data = 64'h44; push_type = 2'd1;
        @(posedge clk);
        #1;
        req = 1'b0; op = 3'd0;
        chk("mid_in_exec", 64'(ready), 64'd0);
        reset = 1'b1;
        #1;
        chk("mid_depth", 64'(depth), 64'd0);
        chk("mid_trap",  64'(trap),  64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_ready", 64'(ready), 64'd1);
        chk("mid_depth_after", 64'(depth), 64'd0);
        do_op(PUSH, 64'h55, 2'd2);
        do_op(POP1, 64'h0, 2'd0);
        chk("mid_pop_out0",  out0,       64'h55);
        chk("mid_pop_depth", 64'(depth), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
